// File: rtl/mem_arbiter_pkg.sv
// Shared types for the external-memory arbiter: FSM states, the registered
// command record and ID sizing helpers.
package mem_arbiter_pkg;

  localparam int MAX_REQ    = 8;
  localparam int ID_W       = 3;
  localparam int CMD_ADDR_W = 24;
  localparam int CMD_DATA_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } mem_arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
    logic [ID_W-1:0]       id;
  } cmd_t;

  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_id_fifo.sv
// Register FIFO of requester IDs for outstanding reads, first-word-fall-through.
module mem_arbiter_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory command port with read-ID tracking.
// Define MEM_ARB_STATS_EN to enable the per-sample-period busy counter.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_RD     = 4
) (
  input  logic                          clk_i,
  input  logic                          arst_i,
  input  logic                          sample_tick_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic [NUM_REQ-1:0]            rdata_val_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0]         mem_wdata_o,
  output logic                          mem_read_o,
  output logic                          mem_write_o,
  input  logic                          mem_waitrequest_i,
  input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
  input  logic                          mem_rdata_val_i,
  output logic                          err_o,
  output logic [15:0]                   busy_cnt_o
);

  mem_arb_state_t state_q, state_d;
  cmd_t           cmd_q, cmd_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [NUM_REQ-1:0]    rdata_val_q;
  logic                  err_q;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ID_W-1:0] fifo_dout;
  logic [MAX_REQ-1:0] elig, we_ext;
  logic [ID_W-1:0] cand, pick;
  logic            found;

  // Reads are only eligible while another ID slot is free.
  assign elig   = MAX_REQ'(req_i & (we_i | {NUM_REQ{~fifo_full}}));
  assign we_ext = MAX_REQ'(we_i);

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    last_grant_d = last_grant_q;
    ack_o        = '0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    fifo_push    = 1'b0;
    found        = 1'b0;
    cand         = '0;
    pick         = '0;
    case (state_q)
      IDLE: begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          cand = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
          if (!found && elig[cand]) begin
            found = 1'b1;
            pick  = cand;
          end
        end
        if (found) begin
          cmd_d.we    = we_ext[pick];
          cmd_d.addr  = CMD_ADDR_W'(addr_i[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH]);
          cmd_d.wdata = CMD_DATA_W'(wdata_i[int'(pick)*DATA_WIDTH +: DATA_WIDTH]);
          cmd_d.id    = pick;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        mem_read_o  = ~cmd_q.we;
        mem_write_o = cmd_q.we;
        mem_addr_o  = ADDR_WIDTH'(cmd_q.addr);
        mem_wdata_o = DATA_WIDTH'(cmd_q.wdata);
        if (!mem_waitrequest_i) begin
          ack_o        = NUM_REQ'(MAX_REQ'(1) << cmd_q.id);
          fifo_push    = ~cmd_q.we;
          last_grant_d = cmd_q.id;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      last_grant_q <= last_grant_d;
    end
  end

  mem_arbiter_id_fifo #(
    .DEPTH (MAX_RD),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .push_i  (fifo_push),
    .din_i   (cmd_q.id),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A return with no outstanding ID is dropped and flagged permanently.
  assign fifo_pop = mem_rdata_val_i & ~fifo_empty;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rdata_q     <= '0;
      rdata_val_q <= '0;
      err_q       <= 1'b0;
    end else begin
      rdata_val_q <= fifo_pop ? NUM_REQ'(MAX_REQ'(1) << fifo_dout) : '0;
      if (fifo_pop) rdata_q <= mem_rdata_i;
      if (mem_rdata_val_i && fifo_empty) err_q <= 1'b1;
    end
  end

  assign rdata_o     = rdata_q;
  assign rdata_val_o = rdata_val_q;
  assign err_o       = err_q;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] busy_cnt_q, busy_out_q;

  // The ISSUE cycle that coincides with the tick belongs to the new period.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      busy_cnt_q <= '0;
      busy_out_q <= '0;
    end else if (sample_tick_i) begin
      busy_out_q <= busy_cnt_q;
      busy_cnt_q <= (state_q == ISSUE) ? 16'd1 : 16'd0;
    end else if (state_q == ISSUE && busy_cnt_q != 16'hFFFF) begin
      busy_cnt_q <= busy_cnt_q + 16'd1;
    end
  end

  assign busy_cnt_o = busy_out_q;
`else
  assign busy_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (4 requesters, 24/16-bit, 4 reads).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        arst;
  logic        tick;
  logic [3:0]  req, we;
  logic [95:0] addrV;
  logic [63:0] wdataV;
  logic [3:0]  ack, rdataVal;
  logic [15:0] rdata, memWdata, memRdata, busyCnt;
  logic [23:0] memAddr;
  logic        memRead, memWrite, waitReq, memRdataVal, err;

  int nCompared = 0;
  int nMismatched = 0;
  int nAck;
  logic [3:0] expAck;
  logic [15:0] expBusy;

  always #5 clk = ~clk;

  mem_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(24), .DATA_WIDTH(16), .MAX_RD(4)
  ) dut (
    .clk_i(clk), .arst_i(arst), .sample_tick_i(tick),
    .req_i(req), .we_i(we), .addr_i(addrV), .wdata_i(wdataV),
    .ack_o(ack), .rdata_o(rdata), .rdata_val_o(rdataVal),
    .mem_addr_o(memAddr), .mem_wdata_o(memWdata),
    .mem_read_o(memRead), .mem_write_o(memWrite),
    .mem_waitrequest_i(waitReq), .mem_rdata_i(memRdata),
    .mem_rdata_val_i(memRdataVal), .err_o(err), .busy_cnt_o(busyCnt)
  );

  task step();
    @(posedge clk);
    #1;
  endtask

  task apply_reset();
    arst = 1'b1;
    tick = 1'b0; req = '0; we = '0; addrV = '0; wdataV = '0;
    waitReq = 1'b0; memRdata = '0; memRdataVal = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  task test_reset();
    arst = 1'b1;
    tick = 1'b0; req = 4'b1111; we = 4'b1010; addrV = '1; wdataV = '1;
    waitReq = 1'b0; memRdata = 16'hFFFF; memRdataVal = 1'b0;
    #3;
    nCompared++;
    if ({ack, rdataVal, memRead, memWrite, err} !== 11'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_ctrl got ack=%b rval=%b rd=%b wr=%b err=%b want all 0", ack, rdataVal, memRead, memWrite, err);
    end
    nCompared++;
    if ({memAddr, memWdata, rdata, busyCnt} !== 72'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_data got addr=%h wd=%h rd=%h busy=%h want 0", memAddr, memWdata, rdata, busyCnt);
    end
    apply_reset();
  endtask

  task test_single_write();
    req = 4'b0001; we = 4'b0001;
    addrV[23:0] = 24'h000010; wdataV[15:0] = 16'h1234;
    nCompared++;
    if (ack !== 4'b0000 || memWrite !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL wr_idle got ack=%b wr=%b want 0000 0", ack, memWrite);
    end
    step();
    nCompared++;
    if (memWrite !== 1'b1 || memRead !== 1'b0 || memAddr !== 24'h000010 || memWdata !== 16'h1234) begin
      nMismatched++; $display("[TB] FAIL wr1_cmd got wr=%b rd=%b addr=%h data=%h want 1 0 000010 1234", memWrite, memRead, memAddr, memWdata);
    end
    nCompared++;
    if (ack !== 4'b0001) begin
      nMismatched++; $display("[TB] FAIL wr1_ack got %b want 0001", ack);
    end
    addrV[23:0] = 24'h000011; wdataV[15:0] = 16'h5678;
    step();
    nCompared++;
    if (ack !== 4'b0000 || memWrite !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL wr_gap got ack=%b wr=%b want 0000 0", ack, memWrite);
    end
    step();
    nCompared++;
    if (ack !== 4'b0001 || memWrite !== 1'b1 || memAddr !== 24'h000011 || memWdata !== 16'h5678) begin
      nMismatched++; $display("[TB] FAIL wr2 got ack=%b wr=%b addr=%h data=%h want 0001 1 000011 5678", ack, memWrite, memAddr, memWdata);
    end
    req = 4'b0000;
    step();
    step();
    nCompared++;
    if (ack !== 4'b0000 || memWrite !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL wr_done got ack=%b wr=%b want 0000 0", ack, memWrite);
    end
  endtask

  task test_round_robin();
    apply_reset();
    req = 4'b1111; we = 4'b1111;
    nAck = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ack !== 4'b0000) begin
        expAck = 4'b0001 << (nAck % 4);
        nCompared++;
        if (ack !== expAck) begin
          nMismatched++; $display("[TB] FAIL rr_order[%0d] got %b want %b", nAck, ack, expAck);
        end
        nAck++;
      end
    end
    nCompared++;
    if (nAck !== 10) begin
      nMismatched++; $display("[TB] FAIL rr_count got %0d want 10", nAck);
    end
    req = 4'b0000;
    step();
    step();
  endtask

  task test_stall();
    apply_reset();
    req = 4'b0110; we = 4'b0100; waitReq = 1'b1;
    addrV[47:24] = 24'h000100; addrV[71:48] = 24'h000200; wdataV[47:32] = 16'hCAFE;
    for (int i = 1; i <= 5; i++) begin
      step();
      nCompared++;
      if (memRead !== 1'b1 || memAddr !== 24'h000100 || ack !== 4'b0000) begin
        nMismatched++; $display("[TB] FAIL stall_hold[%0d] got rd=%b addr=%h ack=%b want 1 000100 0000", i, memRead, memAddr, ack);
      end
    end
    step();
    waitReq = 1'b0;
    #1;
    nCompared++;
    if (ack !== 4'b0010 || memRead !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL stall_ack got ack=%b rd=%b want 0010 1", ack, memRead);
    end
    req[1] = 1'b0;
    step();
    nCompared++;
    if (ack !== 4'b0000) begin
      nMismatched++; $display("[TB] FAIL stall_gap got %b want 0000", ack);
    end
    step();
    nCompared++;
    if (ack !== 4'b0100 || memWrite !== 1'b1 || memAddr !== 24'h000200 || memWdata !== 16'hCAFE) begin
      nMismatched++; $display("[TB] FAIL stall_next got ack=%b wr=%b addr=%h data=%h want 0100 1 000200 cafe", ack, memWrite, memAddr, memWdata);
    end
    req[2] = 1'b0;
    step();
    memRdataVal = 1'b1; memRdata = 16'hBEEF;
    step();
    memRdataVal = 1'b0;
    nCompared++;
    if (rdataVal !== 4'b0010 || rdata !== 16'hBEEF || err !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL stall_rdata got val=%b data=%h err=%b want 0010 beef 0", rdataVal, rdata, err);
    end
  endtask

  task test_fifo_full();
    apply_reset();
    req = 4'b1111; we = 4'b0000;
    addrV = {24'h000300, 24'h000200, 24'h000100, 24'h000000};
    nAck = 0;
    for (int i = 0; i < 20 && nAck < 4; i++) begin
      step();
      if (ack !== 4'b0000) begin
        expAck = 4'b0001 << nAck;
        nCompared++;
        if (ack !== expAck || memRead !== 1'b1) begin
          nMismatched++; $display("[TB] FAIL full_rd[%0d] got ack=%b rd=%b want %b 1", nAck, ack, memRead, expAck);
        end
        req = req & ~ack;
        nAck++;
      end
    end
    nCompared++;
    if (nAck !== 4) begin
      nMismatched++; $display("[TB] FAIL full_rd_count got %0d want 4", nAck);
    end
    req = 4'b1001; we = 4'b1000; addrV[23:0] = 24'h000050; wdataV[63:48] = 16'h7777;
    step();
    step();
    nCompared++;
    if (ack !== 4'b1000 || memWrite !== 1'b1 || memWdata !== 16'h7777) begin
      nMismatched++; $display("[TB] FAIL full_wr got ack=%b wr=%b data=%h want 1000 1 7777", ack, memWrite, memWdata);
    end
    req[3] = 1'b0;
    step();
    step();
    nCompared++;
    if (ack !== 4'b0000 || memRead !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL full_block got ack=%b rd=%b want 0000 0", ack, memRead);
    end
    memRdataVal = 1'b1; memRdata = 16'h00A0;
    step();
    nCompared++;
    if (rdataVal !== 4'b0001 || rdata !== 16'h00A0 || ack !== 4'b0000) begin
      nMismatched++; $display("[TB] FAIL ret0 got val=%b data=%h ack=%b want 0001 00a0 0000", rdataVal, rdata, ack);
    end
    memRdata = 16'h00A1;
    step();
    nCompared++;
    if (rdataVal !== 4'b0010 || rdata !== 16'h00A1) begin
      nMismatched++; $display("[TB] FAIL ret1 got val=%b data=%h want 0010 00a1", rdataVal, rdata);
    end
    nCompared++;
    if (ack !== 4'b0001 || memRead !== 1'b1 || memAddr !== 24'h000050) begin
      nMismatched++; $display("[TB] FAIL unblock_rd got ack=%b rd=%b addr=%h want 0001 1 000050", ack, memRead, memAddr);
    end
    req[0] = 1'b0;
    memRdata = 16'h00A2;
    step();
    nCompared++;
    if (rdataVal !== 4'b0100 || rdata !== 16'h00A2) begin
      nMismatched++; $display("[TB] FAIL ret2 got val=%b data=%h want 0100 00a2", rdataVal, rdata);
    end
    memRdata = 16'h00A3;
    step();
    nCompared++;
    if (rdataVal !== 4'b1000 || rdata !== 16'h00A3) begin
      nMismatched++; $display("[TB] FAIL ret3 got val=%b data=%h want 1000 00a3", rdataVal, rdata);
    end
    memRdata = 16'h00A4;
    step();
    memRdataVal = 1'b0;
    nCompared++;
    if (rdataVal !== 4'b0001 || rdata !== 16'h00A4) begin
      nMismatched++; $display("[TB] FAIL ret4 got val=%b data=%h want 0001 00a4", rdataVal, rdata);
    end
    step();
    nCompared++;
    if (rdataVal !== 4'b0000 || err !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL ret_done got val=%b err=%b want 0000 0", rdataVal, err);
    end
  endtask

  task test_err();
    apply_reset();
    step();
    memRdataVal = 1'b1; memRdata = 16'h5555;
    step();
    memRdataVal = 1'b0;
    nCompared++;
    if (rdataVal !== 4'b0000 || err !== 1'b1 || rdata !== 16'h0000) begin
      nMismatched++; $display("[TB] FAIL err_set got val=%b err=%b data=%h want 0000 1 0000", rdataVal, err, rdata);
    end
    step(); step(); step();
    nCompared++;
    if (err !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL err_sticky got %b want 1", err);
    end
    apply_reset();
    nCompared++;
    if (err !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL err_clear got %b want 0", err);
    end
  endtask

  task test_stats();
`ifdef MEM_ARB_STATS_EN
    expBusy = 16'd3;
`else
    expBusy = 16'd0;
`endif
    apply_reset();
    req = 4'b0001; we = 4'b0001;
    nAck = 0;
    for (int i = 0; i < 20 && nAck < 3; i++) begin
      step();
      if (ack !== 4'b0000) begin
        nAck++;
        if (nAck == 3) req = 4'b0000;
      end
    end
    nCompared++;
    if (nAck !== 3) begin
      nMismatched++; $display("[TB] FAIL stats_cmds got %0d want 3", nAck);
    end
    step();
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    nCompared++;
    if (busyCnt !== expBusy) begin
      nMismatched++; $display("[TB] FAIL stats_busy got %0d want %0d", busyCnt, expBusy);
    end
    step(); step(); step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    nCompared++;
    if (busyCnt !== 16'd0) begin
      nMismatched++; $display("[TB] FAIL stats_idle got %0d want 0", busyCnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_stall();
    test_fifo_full();
    test_err();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares one external-memory command port between up to `NUM_REQ` audio effect requesters (delays, loopers, reverb taps). It sits between the pedalboard effect blocks and the memory controller. It issues one command at a time and tracks outstanding reads with an ID FIFO, so each pipelined read return reaches the requester that issued it. An optional statistics counter reports memory-port occupancy per audio sample period.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8
- `ADDR_WIDTH`, 24: memory word address width
- `DATA_WIDTH`, 16: memory word width
- `MAX_RD`, 4: outstanding read limit, power of two

Ports:
- `clk_i`  in  1  system clock, single clock domain
- `arst_i`  in  1  asynchronous active-high reset
- `sample_tick_i`  in  1  one-cycle pulse per audio sample
- `req_i`  in  NUM_REQ  per-requester request, held until ack
- `we_i`  in  NUM_REQ  1 = write, 0 = read
- `addr_i`  in  NUM_REQ×ADDR_WIDTH  per-requester address
- `wdata_i`  in  NUM_REQ×DATA_WIDTH  per-requester write data
- `ack_o`  out  NUM_REQ  command accepted by memory (one-hot pulse)
- `rdata_o`  out  DATA_WIDTH  read data, shared by all requesters
- `rdata_val_o`  out  NUM_REQ  one-hot read-data valid
- `mem_addr_o`  out  ADDR_WIDTH, `mem_wdata_o`  out  DATA_WIDTH, `mem_read_o`  out  1, `mem_write_o`  out  1: command to controller
- `mem_waitrequest_i`  in  1  controller stall
- `mem_rdata_i`  in  DATA_WIDTH, `mem_rdata_val_i`  in  1: pipelined read return, in order
- `err_o`  out  1  sticky: read return arrived with no outstanding ID
- `busy_cnt_o`  out  16  command-active cycles in the previous sample period

## Operation
- FSM states are `IDLE` and `ISSUE`.
- In `IDLE`:
  - Eligible requesters are `req_i[i] & (we_i[i] | !rd_fifo_full)`.
  - Round-robin pick starts at `last_grant+1` and wraps modulo `NUM_REQ`.
  - If any requester is eligible, register its grant index, address, data and type, then go to `ISSUE`.
- In `ISSUE`:
  - Drive `mem_read_o` or `mem_write_o` with the registered command.
  - Hold while `mem_waitrequest_i=1`.
  - On accept (`!mem_waitrequest_i`), `ack_o[grant]=1` combinationally in that same cycle.
  - On accept, update `last_grant`. For a read, push the grant index into the ID FIFO. Return to `IDLE`.
- Read return:
  - On `mem_rdata_val_i`, pop the ID. Next cycle, `rdata_o=mem_rdata_i` and `rdata_val_o[id]=1`.
  - If the FIFO is empty on a return, drop the data and set `err_o`. `err_o` clears only on reset.
- Boundaries:
  - Push and pop in the same cycle are both allowed; the FIFO count is unchanged.
  - A read is never issued when the FIFO holds `MAX_RD` entries; writes still proceed.
  - A request deasserted while in `IDLE` is simply not picked. Requesters must not drop `req_i` while granted.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in `IDLE`, FIFO empty.
  - `last_grant=NUM_REQ-1`, so requester 0 wins first.
- Issue timing:
  - A request sampled in `IDLE` at cycle N gives the command on the memory port at N+1.
  - With `waitrequest=0`, `ack_o` is at N+1.
  - Peak throughput is one command per 2 cycles.
- Read data reaches the requester 1 cycle after `mem_rdata_val_i`.
- Worst-case grant wait, with no stalls, is `2·(NUM_REQ-1)` cycles.
- Reset asserted mid-command abandons it with no ack. The memory controller shares `arst_i`.

## Configuration
- `MEM_ARB_STATS_EN` defined:
  - A 16-bit counter increments every cycle in `ISSUE` and saturates at 0xFFFF.
  - On `sample_tick_i`, the counter value is latched to `busy_cnt_o` and the counter restarts at 0. The `ISSUE` cycle coinciding with the tick is counted into the new period.
- `MEM_ARB_STATS_EN` undefined: no counter logic; `busy_cnt_o` is tied to 0.

## Structure
- Package `mem_arbiter_pkg` holds:
  - the state enum `mem_arb_state_t` (`IDLE`, `ISSUE`)
  - `ID_WIDTH = $clog2(NUM_REQ)` helper function
  - the `cmd_t` struct (we, addr, wdata, id)
- Sub-module `mem_arbiter_id_fifo`:
  - `MAX_RD`-deep register FIFO of IDs
  - ports push, pop, full, empty, dout (first-word-fall-through)

## Test plan
- Single requester 2 writes addr 0x000010 data 0x1234, `waitrequest=0` -> `mem_write_o` at N+1, `ack_o=0001` same cycle.
- All 4 requesting continuously -> grant order 0,1,2,3,0,...; no requester acked twice before the others.
- `waitrequest` held 5 cycles during a read by requester 1 -> command stable for 5 cycles; `ack_o[1]` in the 6th; no other grant meanwhile.
- 4 reads outstanding, requester 0 read plus requester 3 write pending -> write issued, read blocked until first return; returns with data 0xA0..0xA3 arrive as one-hot `rdata_val_o` in issue order.
- `mem_rdata_val_i` with FIFO empty -> no `rdata_val_o`, `err_o=1` held until reset.
- Stats build: 3 commands with 0 stall in a tick period -> `busy_cnt_o=3` after the next `sample_tick_i`. Non-stats build -> `busy_cnt_o=0`.
